// File: rtl/pu_or1k_store_buffer.sv
// rtl/pu_or1k_store_buffer.sv - OR1K LSU store buffer: FIFO of {pc, adr, dat, bsel, atomic} over a sync-read RAM.
// Optional occupancy output level_o when PU_OR1K_STORE_BUFFER_COUNT_EN is defined.
module pu_or1k_store_buffer #(
  parameter int DEPTH_WIDTH          = 4,
  parameter int OPTION_OPERAND_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   pc_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   dat_i,
  input  logic [OPTION_OPERAND_WIDTH/8-1:0] bsel_i,
  input  logic                              atomic_i,
  input  logic                              write_i,
  output logic [OPTION_OPERAND_WIDTH-1:0]   pc_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   dat_o,
  output logic [OPTION_OPERAND_WIDTH/8-1:0] bsel_o,
  output logic                              atomic_o,
  input  logic                              read_i,
  output logic                              full_o,
  output logic                              empty_o
`ifdef PU_OR1K_STORE_BUFFER_COUNT_EN
  ,
  output logic [DEPTH_WIDTH:0]              level_o
`endif
);

  localparam int W     = OPTION_OPERAND_WIDTH;
  localparam int BW    = OPTION_OPERAND_WIDTH / 8;
  localparam int EW    = 3 * W + BW + 1;
  localparam int DEPTH = 1 << DEPTH_WIDTH;

  logic [DEPTH_WIDTH:0]   r_wr_ptr;
  logic [DEPTH_WIDTH:0]   r_rd_ptr;
  logic [EW-1:0]          r_mem [DEPTH];
  logic [EW-1:0]          r_rdata;

  logic                   w_read;
  logic                   w_write;
  logic [DEPTH_WIDTH:0]   w_one;
  logic [DEPTH_WIDTH:0]   w_rd_ptr_inc;
  logic [DEPTH_WIDTH-1:0] w_waddr;
  logic [DEPTH_WIDTH-1:0] w_raddr;
  logic [EW-1:0]          w_wdata;

  assign w_one        = {{DEPTH_WIDTH{1'b0}}, 1'b1};
  assign empty_o      = (r_wr_ptr == r_rd_ptr);
  assign full_o       = (r_wr_ptr[DEPTH_WIDTH-1:0] == r_rd_ptr[DEPTH_WIDTH-1:0]) &&
                        (r_wr_ptr[DEPTH_WIDTH] != r_rd_ptr[DEPTH_WIDTH]);

  // A full buffer still takes a write when the head leaves in the same cycle.
  assign w_read       = read_i & ~empty_o & ~rst;
  assign w_write      = write_i & (~full_o | (read_i & ~empty_o)) & ~rst;

  assign w_rd_ptr_inc = r_rd_ptr + w_one;
  assign w_waddr      = r_wr_ptr[DEPTH_WIDTH-1:0];
  assign w_raddr      = w_read ? w_rd_ptr_inc[DEPTH_WIDTH-1:0] : r_rd_ptr[DEPTH_WIDTH-1:0];
  assign w_wdata      = {pc_i, adr_i, dat_i, bsel_i, atomic_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + w_one;
      if (w_read)  r_rd_ptr <= w_rd_ptr_inc;
    end
  end

  // Simple dual-port RAM; the read port is always enabled and bypasses a same-address write.
  always_ff @(posedge clk) begin
    if (w_write) r_mem[w_waddr] <= w_wdata;
    if (w_write && (w_waddr == w_raddr)) r_rdata <= w_wdata;
    else                                 r_rdata <= r_mem[w_raddr];
  end

  assign {pc_o, adr_o, dat_o, bsel_o, atomic_o} = r_rdata;

`ifdef PU_OR1K_STORE_BUFFER_COUNT_EN
  assign level_o = r_wr_ptr - r_rd_ptr;
`endif

endmodule

// File: tb/tb_pu_or1k_store_buffer.sv
// tb/tb_pu_or1k_store_buffer.sv - randomized store buffer bench checked against a queue model.
module tb_pu_or1k_store_buffer;

  localparam int DW    = 4;
  localparam int W     = 32;
  localparam int DEPTH = 1 << DW;

  typedef struct {
    logic [W-1:0]   pc;
    logic [W-1:0]   adr;
    logic [W-1:0]   dat;
    logic [W/8-1:0] bsel;
    logic           atomic;
  } entry_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   pc_i, adr_i, dat_i;
  logic [W/8-1:0] bsel_i;
  logic           atomic_i, write_i, read_i;
  logic [W-1:0]   pc_o, adr_o, dat_o;
  logic [W/8-1:0] bsel_o;
  logic           atomic_o, full_o, empty_o;
`ifdef PU_OR1K_STORE_BUFFER_COUNT_EN
  logic [DW:0]    level_o;
`endif

  entry_t model_q[$];
  int     n_total = 0;
  int     n_bad   = 0;

  pu_or1k_store_buffer #(.DEPTH_WIDTH(DW), .OPTION_OPERAND_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .pc_i     (pc_i),
    .adr_i    (adr_i),
    .dat_i    (dat_i),
    .bsel_i   (bsel_i),
    .atomic_i (atomic_i),
    .write_i  (write_i),
    .pc_o     (pc_o),
    .adr_o    (adr_o),
    .dat_o    (dat_o),
    .bsel_o   (bsel_o),
    .atomic_o (atomic_o),
    .read_i   (read_i),
    .full_o   (full_o),
    .empty_o  (empty_o)
`ifdef PU_OR1K_STORE_BUFFER_COUNT_EN
    ,
    .level_o  (level_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    int sz;
    sz = model_q.size();
    check("empty", 64'(empty_o), 64'(sz == 0));
    check("full",  64'(full_o),  64'(sz == DEPTH));
`ifdef PU_OR1K_STORE_BUFFER_COUNT_EN
    check("level", 64'(level_o), 64'(sz));
`endif
    if (sz > 0) begin
      check("head_pc",     64'(pc_o),     64'(model_q[0].pc));
      check("head_adr",    64'(adr_o),    64'(model_q[0].adr));
      check("head_dat",    64'(dat_o),    64'(model_q[0].dat));
      check("head_bsel",   64'(bsel_o),   64'(model_q[0].bsel));
      check("head_atomic", 64'(atomic_o), 64'(model_q[0].atomic));
    end
  endtask

  // One clock: drive, let the edge happen, apply the queue rules, check 1 time unit later.
  task automatic step(input logic w, input logic r, input entry_t e);
    bit do_r, do_w;
    write_i  = w;
    read_i   = r;
    pc_i     = e.pc;
    adr_i    = e.adr;
    dat_i    = e.dat;
    bsel_i   = e.bsel;
    atomic_i = e.atomic;
    do_r = r && (model_q.size() > 0);
    do_w = w && ((model_q.size() < DEPTH) || do_r);
    @(posedge clk);
    if (do_r) void'(model_q.pop_front());
    if (do_w) model_q.push_back(e);
    #1;
    write_i = 1'b0;
    read_i  = 1'b0;
    check_state();
  endtask

  function automatic entry_t rand_entry();
    entry_t e;
    e.pc     = $urandom;
    e.adr    = $urandom;
    e.dat    = $urandom;
    e.bsel   = 4'($urandom_range(0, 15));
    e.atomic = 1'($urandom_range(0, 1));
    return e;
  endfunction

  function automatic entry_t dat_entry(input logic [W-1:0] d);
    entry_t e;
    e = rand_entry();
    e.dat = d;
    return e;
  endfunction

  initial begin
    entry_t e;
    rst = 1'b1;
    write_i = 1'b0; read_i = 1'b0;
    pc_i = '0; adr_i = '0; dat_i = '0; bsel_i = '0; atomic_i = 1'b0;
    #12;
    check_state();
    rst = 1'b0;

    // single entry: visible right after the write edge and still there a cycle later
    e.pc = 32'h100; e.adr = 32'h2000; e.dat = 32'hDEADBEEF; e.bsel = 4'hF; e.atomic = 1'b0;
    step(1'b1, 1'b0, e);
    check("first_dat", 64'(dat_o), 64'h0000_0000_DEAD_BEEF);
    step(1'b0, 1'b0, rand_entry());
    check("first_pc", 64'(pc_o), 64'h100);
    step(1'b0, 1'b1, rand_entry());

    // fill, overflow attempt, ordered drain
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, dat_entry(W'(i)));
    check("full_after_16", 64'(full_o), 64'd1);
    step(1'b1, 1'b0, dat_entry(32'h99));
    check("overflow_head", 64'(dat_o), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_order", 64'(dat_o), 64'(i));
      step(1'b0, 1'b1, rand_entry());
    end
    check("empty_after_drain", 64'(empty_o), 64'd1);

    // simultaneous read+write while full
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, dat_entry(W'(i + 16)));
    step(1'b1, 1'b1, dat_entry(32'hAA));
    check("full_rw_full", 64'(full_o), 64'd1);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("full_rw_last", 64'(dat_o), 64'hAA);
      step(1'b0, 1'b1, rand_entry());
    end

    // simultaneous read+write while empty: only the write happens
    step(1'b1, 1'b1, dat_entry(32'h77));
    check("empty_rw_not_empty", 64'(empty_o), 64'd0);
    check("empty_rw_dat", 64'(dat_o), 64'h77);
    step(1'b0, 1'b1, rand_entry());

    // random interleaving across pointer wraps
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0), rand_entry());

    // async reset with entries held
    while (model_q.size() > 0) step(1'b0, 1'b1, rand_entry());
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, rand_entry());
    #2 rst = 1'b1;
    #1;
    model_q.delete();
    check("async_rst_empty", 64'(empty_o), 64'd1);
    check_state();
    #1 rst = 1'b0;
    step(1'b1, 1'b0, dat_entry(32'h55));
    check("post_rst_dat", 64'(dat_o), 64'h55);
    step(1'b0, 1'b1, rand_entry());

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
